// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven state machine with a fixed-point level
// accumulator, and a one-cycle sample scaler that feeds the pwm compare input.
module adsr_envelope #(
    parameter int COMPARE_WIDTH = 9,
    parameter int LEVEL_WIDTH   = 8,
    parameter int FRAC_BITS     = 8,
    localparam int ACC_W        = LEVEL_WIDTH + FRAC_BITS
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_gate,
    input  logic                     i_tick,
    input  logic [ACC_W-1:0]         i_attack_step,
    input  logic [ACC_W-1:0]         i_decay_step,
    input  logic [LEVEL_WIDTH-1:0]   i_sustain_level,
    input  logic [ACC_W-1:0]         i_release_step,
    input  logic [COMPARE_WIDTH-1:0] i_sample,
    input  logic                     i_sample_valid,
    output logic [COMPARE_WIDTH-1:0] o_compare,
    output logic                     o_compare_valid,
    output logic [LEVEL_WIDTH-1:0]   o_level,
    output logic [2:0]               o_state
);

    localparam int PROD_W = COMPARE_WIDTH + LEVEL_WIDTH + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             gate_d;

    logic             rise;
    logic             fall;
    logic [ACC_W:0]   att_sum;
    logic [ACC_W-1:0] sus_acc;
    logic             att_done;
    logic             dec_done;
    logic             rel_done;

    // Full-scale level maps to a gain of 2^LEVEL_WIDTH so a full envelope
    // passes the sample through unchanged.
    function automatic logic [LEVEL_WIDTH:0] level_gain(input logic [LEVEL_WIDTH-1:0] lvl);
        if (lvl == {LEVEL_WIDTH{1'b1}})
            return {1'b1, {LEVEL_WIDTH{1'b0}}};
        return {1'b0, lvl};
    endfunction

    function automatic logic [COMPARE_WIDTH-1:0] scale_sample(
        input logic [COMPARE_WIDTH-1:0] sample,
        input logic [LEVEL_WIDTH:0]     gain
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(sample) * PROD_W'(gain);
        return COMPARE_WIDTH'(prod >> LEVEL_WIDTH);
    endfunction

    always_comb begin
        rise     = i_gate & ~gate_d;
        fall     = ~i_gate & gate_d;
        att_sum  = {1'b0, acc} + {1'b0, i_attack_step};
        sus_acc  = {i_sustain_level, {FRAC_BITS{1'b0}}};
        att_done = (att_sum >= {1'b0, ACC_MAX});
        // acc - step <= S rewritten as step >= acc - S so it cannot underflow
        dec_done = (acc <= sus_acc) || (i_decay_step >= (acc - sus_acc));
        rel_done = (acc <= i_release_step);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            acc    <= '0;
            gate_d <= 1'b0;
        end else begin
            gate_d <= i_gate;
            if (rise) begin
                state <= ST_ATTACK;
            end else if (fall && state != ST_IDLE) begin
                state <= ST_RELEASE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        acc <= '0;
                    end
                    ST_ATTACK: begin
                        if (i_tick) begin
                            if (att_done) begin
                                acc   <= ACC_MAX;
                                state <= ST_DECAY;
                            end else begin
                                acc <= att_sum[ACC_W-1:0];
                            end
                        end
                    end
                    ST_DECAY: begin
                        if (i_tick) begin
                            if (dec_done) begin
                                acc   <= sus_acc;
                                state <= ST_SUSTAIN;
                            end else begin
                                acc <= acc - i_decay_step;
                            end
                        end
                    end
                    ST_SUSTAIN: begin
                        acc <= sus_acc;
                    end
                    ST_RELEASE: begin
                        if (i_tick) begin
                            if (rel_done) begin
                                acc   <= '0;
                                state <= ST_IDLE;
                            end else begin
                                acc <= acc - i_release_step;
                            end
                        end
                    end
                    default: begin
                        acc   <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Stage p0 -> p1: scale the sample by the level present in its own cycle
    logic [COMPARE_WIDTH-1:0] compare_p1;
    logic                     vld_p1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            compare_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= i_sample_valid;
            if (i_sample_valid) begin
                if (state == ST_IDLE)
                    compare_p1 <= '0;
                else
                    compare_p1 <= scale_sample(i_sample, level_gain(acc[ACC_W-1:FRAC_BITS]));
            end
        end
    end

    assign o_compare       = compare_p1;
    assign o_compare_valid = vld_p1;
    assign o_level         = acc[ACC_W-1:FRAC_BITS];
    assign o_state         = state;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: envelope trajectory checks plus a
// scoreboard queue for scaled compare outputs.
module tb_adsr_envelope;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_gate;
    logic        i_tick;
    logic [15:0] i_attack_step;
    logic [15:0] i_decay_step;
    logic [7:0]  i_sustain_level;
    logic [15:0] i_release_step;
    logic [8:0]  i_sample;
    logic        i_sample_valid;
    logic [8:0]  o_compare;
    logic        o_compare_valid;
    logic [7:0]  o_level;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    adsr_envelope dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_gate          (i_gate),
        .i_tick          (i_tick),
        .i_attack_step   (i_attack_step),
        .i_decay_step    (i_decay_step),
        .i_sustain_level (i_sustain_level),
        .i_release_step  (i_release_step),
        .i_sample        (i_sample),
        .i_sample_valid  (i_sample_valid),
        .o_compare       (o_compare),
        .o_compare_valid (o_compare_valid),
        .o_level         (o_level),
        .o_state         (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic tick();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic send_sample(input string tag, input logic [8:0] s, input logic [8:0] exp);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        sb_q.push_back(e);
        i_sample       = s;
        i_sample_valid = 1'b1;
        step();
        i_sample_valid = 1'b0;
        check({tag, "_valid"}, o_compare_valid, 1);
        step();
        check({tag, "_pulse_end"}, o_compare_valid, 0);
        check({tag, "_hold"}, o_compare, exp);
    endtask

    task automatic check_env(input string tag, input logic [2:0] st, input logic [7:0] lvl);
        check({tag, "_state"}, o_state, st);
        check({tag, "_level"}, o_level, lvl);
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest pending sample
    always @(negedge i_clk) begin
        if (!i_rst && o_compare_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check(sb_e.tag, o_compare, sb_e.val);
            end
        end
    end

    initial begin
        i_rst = 1'b1;
        i_gate = 1'b0;
        i_tick = 1'b0;
        i_attack_step = '0;
        i_decay_step = '0;
        i_sustain_level = '0;
        i_release_step = '0;
        i_sample = '0;
        i_sample_valid = 1'b0;
        repeat (3) step();
        check_env("reset", 3'd0, 8'h00);
        check("reset_compare", o_compare, 0);
        check("reset_valid", o_compare_valid, 0);
        i_rst = 1'b0;
        step();
        check_env("idle", 3'd0, 8'h00);

        send_sample("idle_scale", 9'd300, 9'd0);

        i_attack_step = 16'h1000;
        i_gate = 1'b1;
        step();
        check_env("rise", 3'd1, 8'h00);
        repeat (15) tick();
        check_env("attack15", 3'd1, 8'hF0);
        send_sample("attack_scale", 9'd200, 9'd187);
        tick();
        check_env("attack16", 3'd2, 8'hFF);
        send_sample("full_scale", 9'd200, 9'd200);

        i_decay_step = 16'h0800;
        i_sustain_level = 8'h80;
        repeat (15) tick();
        check_env("decay15", 3'd2, 8'h87);
        tick();
        check_env("decay16", 3'd3, 8'h80);
        send_sample("half_scale", 9'd200, 9'd100);

        i_sustain_level = 8'h60;
        step();
        check_env("sustain_track", 3'd3, 8'h60);
        i_sustain_level = 8'h80;
        step();
        check_env("sustain_back", 3'd3, 8'h80);

        i_release_step = 16'h0100;
        i_gate = 1'b0;
        step();
        check_env("fall", 3'd4, 8'h80);
        repeat (64) tick();
        check_env("release64", 3'd4, 8'h40);
        i_gate = 1'b1;
        tick();
        check_env("retrigger_tick", 3'd1, 8'h40);
        tick();
        check_env("retrigger_rise", 3'd1, 8'h50);

        #3 i_rst = 1'b1;
        #1;
        check_env("async_reset", 3'd0, 8'h00);
        check("async_reset_compare", o_compare, 0);
        step();
        step();
        i_rst = 1'b0;
        step();
        check_env("gate_through_reset", 3'd1, 8'h00);

        i_attack_step = 16'hFFFF;
        tick();
        check_env("attack_sat", 3'd2, 8'hFF);
        i_decay_step = 16'h8000;
        tick();
        check_env("decay_clamp", 3'd3, 8'h80);
        i_gate = 1'b0;
        step();
        check_env("fall2", 3'd4, 8'h80);
        repeat (127) tick();
        check_env("release127", 3'd4, 8'h01);
        tick();
        check_env("release128", 3'd0, 8'h00);
        tick();
        check_env("idle_tick", 3'd0, 8'h00);

        i_attack_step = 16'h1000;
        i_gate = 1'b1;
        step();
        repeat (3) tick();
        check_env("attack3", 3'd1, 8'h30);
        i_attack_step = 16'h0000;
        tick();
        check_env("attack_hold", 3'd1, 8'h30);
        i_gate = 1'b0;
        step();
        check_env("fall_in_attack", 3'd4, 8'h30);
        send_sample("release_scale", 9'd256, 9'd48);

        step();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
